// File: rtl/prod_accumulator_pkg.sv
// Shared definitions for the product accumulator: FSM state encoding and
// default datapath widths matching the 4x4 array multiplier output.
package prod_accumulator_pkg;

   localparam int DEF_PW = 8;
   localparam int DEF_AW = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/acc_adder.sv
// Parameterised ripple-carry adder used by the accumulator datapath;
// exposes the carry out so the caller can track wrap-around.
module acc_adder #(
   parameter int AW = 10
) (
   input  logic [AW-1:0] a_i,
   input  logic [AW-1:0] b_i,
   input  logic          cin_i,
   output logic [AW-1:0] sum_o,
   output logic          cout_o
);

   logic [AW:0] carry;

   assign carry[0] = cin_i;

   for (genvar i = 0; i < AW; i++) begin : g_fa
      assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
   end

   assign cout_o = carry[AW];

endmodule

// File: rtl/prod_accumulator.sv
// Sums N_TERMS unsigned multiplier products into a wrapping AW-bit total
// and hands the result downstream; overflow records any carry in the run.
module prod_accumulator
   import prod_accumulator_pkg::*;
#(
   parameter int PW      = DEF_PW,
   parameter int AW      = DEF_AW,
   parameter int N_TERMS = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [PW-1:0]                  product,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [AW-1:0]                  sum,
   output logic                           sum_valid,
   input  logic                           sum_ready,
   output logic                           overflow,
   output logic                           busy,
   output logic [$clog2(N_TERMS+1)-1:0]   count,
   output logic [1:0]                     dbg_state
);

   localparam int CW = $clog2(N_TERMS + 1);

   // Handshakes: a product moves on a cycle with in_valid & in_ready, the
   // result moves on a cycle with sum_valid & sum_ready; valid never drops
   // before its transfer, and ready depends on state only.

   state_e          state_q, state_d;
   logic [AW-1:0]   sum_q,   sum_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q,   ovf_d;

   logic [AW-1:0]   prod_ext;
   logic [AW-1:0]   add_sum;
   logic            add_carry;

   assign prod_ext = AW'(product);

   acc_adder #(.AW(AW)) u_acc_adder (
      .a_i    (sum_q),
      .b_i    (prod_ext),
      .cin_i  (1'b0),
      .sum_o  (add_sum),
      .cout_o (add_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sum_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ACC;
               sum_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
            end
         end
         ST_ACC: begin
            if (in_valid) begin
               sum_d   = add_sum;
               ovf_d   = ovf_q | add_carry;
               count_d = count_q + CW'(1);
               if (count_q == CW'(N_TERMS - 1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            // start is ignored here, even when it coincides with sum_ready.
            if (sum_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == ST_ACC);
   assign sum_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign sum       = sum_q;
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign dbg_state = state_q;

endmodule

// File: doc/prod_accumulator.md
Name: prod_accumulator

Overview:
- Downstream stage of the 4x4 array multiplier.
- Consumes a stream of 8-bit products P through a valid/ready handshake.
- Sums exactly N_TERMS products into a wider accumulator, then presents the total on an output valid/ready handshake.
- Used to build dot products (sum of X[i]*Y[i]) on top of the combinational multiplier.

Parameters:
- PW, 8, product width; matches the multiplier output P[7:0].
- AW, 10, accumulator/sum width; the result wraps modulo 2^AW.
- N_TERMS, 4, number of products per accumulation run; must be >= 1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a run, honoured only in IDLE.
- product  input  PW  multiplier product (unsigned).
- in_valid  input  1  product is valid this cycle.
- in_ready  output  1  block accepts a product this cycle.
- sum  output  AW  accumulated result.
- sum_valid  output  1  sum is final and stable.
- sum_ready  input  1  consumer takes sum this cycle.
- overflow  output  1  sticky; carry out of the AW-bit accumulator during the current run.
- busy  output  1  state != IDLE.
- count  output  $clog2(N_TERMS+1)  products accepted in the current run.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - sum=0, count=0, overflow=0.
  - in_ready=0, sum_valid=0, busy=0.
  - Takes effect immediately, including mid-run; a partial run is discarded.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - in_ready=0, sum_valid=0.
  - sum keeps the last result until a new start.
  - On start=1: next cycle state=ACC, sum=0, count=0, overflow=0.
- ACC:
  - in_ready=1 (combinational from state only).
  - A transfer is the cycle where in_valid & in_ready.
  - On each transfer: {c, sum} <= sum + zero-extended product; overflow <= overflow | c; count <= count+1.
  - If count==N_TERMS-1 at the transfer, the next state is DONE.
  - No transfer: all registers hold; gaps on in_valid are allowed.
- DONE:
  - sum_valid=1, in_ready=0; sum, count and overflow are held stable.
  - On sum_ready=1: next state is IDLE and sum_valid drops the next cycle.
  - sum_valid never drops without sum_ready.
- Latency: sum_valid rises on the cycle after the last product transfer.
  - Minimum run: 1 start cycle + N_TERMS transfer cycles.
- start while busy (ACC or DONE): ignored, with no effect on state or registers.
- start and sum_ready in the same DONE cycle: the run completes (IDLE); start is ignored.
- Products offered in IDLE/DONE are not accepted (in_ready=0); the upstream must hold them.
- Width rules:
  - The product is zero-extended to AW+1 bits before the add.
  - sum wraps modulo 2^AW; overflow is set on any carry out and stays set until the next start or reset.
- N_TERMS=1: exactly one transfer, then DONE.

Decomposition:
- Shared header/package: FSM state encodings as localparams (IDLE=2'd0, ACC=2'd1, DONE=2'd2) and the default widths PW/AW.
- One natural sub-module: acc_adder.
  - Parameterised AW-bit ripple-carry adder producing sum and carry_out.
  - Same structure as the team's existing rca blocks.
- The FSM, counter and registers stay in prod_accumulator.

Test Plan:
- Sums and handshake:
  - start, then products 225,225,225,225 back-to-back (N_TERMS=4, AW=10) -> sum_valid one cycle after the 4th transfer, sum=900, overflow=0, count=4.
  - Products 1,2,3,4 with in_valid low for 2 cycles between each -> in_ready stays 1 in ACC, sum=10, sum_valid only after the 4th transfer.
  - Complete a run, hold sum_ready=0 for 5 cycles -> sum_valid=1 and sum stable throughout; sum_ready=1 -> IDLE next cycle, busy=0, sum_valid=0.
- Overflow: N_TERMS=8, AW=10, eight products of 225 -> sum=1800-1024=776, overflow=1.
  - A fresh start then clears overflow to 0 and sum to 0.
- Reset and stray start:
  - Run in progress after 2 transfers (products 5,6), pulse rst_n low asynchronously mid-cycle -> outputs immediately sum=0, count=0, overflow=0, busy=0.
  - After rst_n returns high, a new run with products 1,1,1,1 -> sum=4.
  - start pulse during ACC (after 1 transfer, product 7) and during DONE -> ignored; the final sum reflects all 4 products of the original run, and count is not reset.
